video_timing_gen: RTL and testbench

- Parametrised raster timing generator for the HDMI/VGA video path. It replaces the fixed 640x480 counter/sync logic inside the HDMI generator.
- Produces pixel coordinates for the shader, plus draw-area, hsync, vsync, line-start and frame-start flags.
- The flags are delayed by a configurable pipeline depth so they stay aligned with a multi-stage shader feeding the TMDS encoders.
- Adds resolution/porch parameters, selectable sync polarity, a pixel-clock enable and frame/line markers.

---
 rtl/video_timing_gen_if.sv | 23 ++
 rtl/video_timing_gen.sv | 116 +++++++++++
 tb/tb_video_timing_gen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - raster timing bundle: enable in, coordinates and sync flags out
interface video_timing_if #(
    parameter int COORD_W = 10
);
    logic               enable;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               draw_area;
    logic               hsync;
    logic               vsync;
    logic               line_start;
    logic               frame_start;

    modport master (
        input  enable,
        output x, y, draw_area, hsync, vsync, line_start, frame_start
    );

    modport slave (
        output enable,
        input  x, y, draw_area, hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised raster counter with pipelined sync/area/marker flags
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int PIPE_DLY = 1,
    parameter int COORD_W  = 10
) (
    input  logic pixclk,
    input  logic reset,
    video_timing_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One extra bit so region bounds equal to 2**COORD_W still compare correctly
    localparam int CW1 = COORD_W + 1;

    if (H_TOTAL - 1 >= (1 << COORD_W)) begin : g_h_range_err
        $error("video_timing_gen: H_TOTAL-1 does not fit in COORD_W bits");
    end
    if (V_TOTAL - 1 >= (1 << COORD_W)) begin : g_v_range_err
        $error("video_timing_gen: V_TOTAL-1 does not fit in COORD_W bits");
    end
    if (PIPE_DLY < 1) begin : g_dly_err
        $error("video_timing_gen: PIPE_DLY must be at least 1");
    end

    localparam logic [CW1-1:0] H_LAST  = CW1'(H_TOTAL - 1);
    localparam logic [CW1-1:0] V_LAST  = CW1'(V_TOTAL - 1);
    localparam logic [CW1-1:0] H_ACT_E = CW1'(H_ACTIVE);
    localparam logic [CW1-1:0] V_ACT_E = CW1'(V_ACTIVE);
    localparam logic [CW1-1:0] HS_BEG  = CW1'(H_ACTIVE + H_FP);
    localparam logic [CW1-1:0] HS_END  = CW1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW1-1:0] VS_BEG  = CW1'(V_ACTIVE + V_FP);
    localparam logic [CW1-1:0] VS_END  = CW1'(V_ACTIVE + V_FP + V_SYNC);

    // Flag bit positions inside a pipeline stage
    localparam int F_ACT = 4;
    localparam int F_HS  = 3;
    localparam int F_VS  = 2;
    localparam int F_LS  = 1;
    localparam int F_FS  = 0;

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [CW1-1:0]     x_e, y_e;
    logic               x_last, y_last;
    logic [4:0]         raw_flags;
    logic [4:0]         pipe_q [PIPE_DLY];

    assign x_e    = {1'b0, x_q};
    assign y_e    = {1'b0, y_q};
    assign x_last = (x_e == H_LAST);
    assign y_last = (y_e == V_LAST);

    // Raw flags describe the coordinate currently on x/y; vsync spans whole lines
    assign raw_flags[F_ACT] = (x_e < H_ACT_E) && (y_e < V_ACT_E);
    assign raw_flags[F_HS]  = (x_e >= HS_BEG) && (x_e < HS_END);
    assign raw_flags[F_VS]  = (y_e >= VS_BEG) && (y_e < VS_END);
    assign raw_flags[F_LS]  = (x_q == '0);
    assign raw_flags[F_FS]  = (x_q == '0) && (y_q == '0);

    // Next raster position: x wraps every line, y advances only on the x wrap
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (vid.enable) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + COORD_W'(1);
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end
    end

    // Coordinate registers; a low enable leaves them untouched via x_d/y_d
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Flag delay line advances in lockstep with the counters so alignment survives enable gaps
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (vid.enable) begin
            pipe_q[0] <= raw_flags;
            for (int i = 1; i < PIPE_DLY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.draw_area   = pipe_q[PIPE_DLY-1][F_ACT];
    assign vid.hsync       = pipe_q[PIPE_DLY-1][F_HS] ^ ~HS_POL;
    assign vid.vsync       = pipe_q[PIPE_DLY-1][F_VS] ^ ~VS_POL;
    assign vid.line_start  = pipe_q[PIPE_DLY-1][F_LS];
    assign vid.frame_start = pipe_q[PIPE_DLY-1][F_FS];
endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized-enable check of two configurations against an arithmetic raster model
module tb_video_timing_gen;
    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        int dly;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        int x, y;
        bit act, hs, vs, ls, fs;
    } exp_t;

    logic pixclk = 1'b0;
    logic reset;
    always #5 pixclk = ~pixclk;

    video_timing_if #(.COORD_W(10)) va ();
    video_timing_if #(.COORD_W(4))  vb ();

    video_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(4),   .V_FP(1),  .V_SYNC(2),  .V_BP(1),
        .HS_POL(1'b1),  .VS_POL(1'b1), .PIPE_DLY(1), .COORD_W(10)
    ) dut_a (
        .pixclk(pixclk),
        .reset (reset),
        .vid   (va.master)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(3), .COORD_W(4)
    ) dut_b (
        .pixclk(pixclk),
        .reset (reset),
        .vid   (vb.master)
    );

    cfg_t cfg_a, cfg_b;
    int   n_a, n_b;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Expected outputs after n enabled cycles since reset release
    function automatic exp_t ref_at(cfg_t c, int n);
        exp_t e;
        int   ht, vt, m, mx, my;
        ht  = c.ha + c.hfp + c.hsw + c.hbp;
        vt  = c.va + c.vfp + c.vsw + c.vbp;
        e.x = n % ht;
        e.y = (n / ht) % vt;
        if (n < c.dly) begin
            e.act = 1'b0;
            e.hs  = ~c.hp;
            e.vs  = ~c.vp;
            e.ls  = 1'b0;
            e.fs  = 1'b0;
        end else begin
            m     = n - c.dly;
            mx    = m % ht;
            my    = (m / ht) % vt;
            e.act = (mx < c.ha) && (my < c.va);
            e.hs  = ((mx >= c.ha + c.hfp) && (mx < c.ha + c.hfp + c.hsw)) ? c.hp : ~c.hp;
            e.vs  = ((my >= c.va + c.vfp) && (my < c.va + c.vfp + c.vsw)) ? c.vp : ~c.vp;
            e.ls  = (mx == 0);
            e.fs  = (mx == 0) && (my == 0);
        end
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_a();
        exp_t e;
        e = ref_at(cfg_a, n_a);
        chk("A_x",           32'(va.x),           32'(e.x));
        chk("A_y",           32'(va.y),           32'(e.y));
        chk("A_draw_area",   32'(va.draw_area),   32'(e.act));
        chk("A_hsync",       32'(va.hsync),       32'(e.hs));
        chk("A_vsync",       32'(va.vsync),       32'(e.vs));
        chk("A_line_start",  32'(va.line_start),  32'(e.ls));
        chk("A_frame_start", 32'(va.frame_start), 32'(e.fs));
    endtask

    task automatic check_b();
        exp_t e;
        e = ref_at(cfg_b, n_b);
        chk("B_x",           32'(vb.x),           32'(e.x));
        chk("B_y",           32'(vb.y),           32'(e.y));
        chk("B_draw_area",   32'(vb.draw_area),   32'(e.act));
        chk("B_hsync",       32'(vb.hsync),       32'(e.hs));
        chk("B_vsync",       32'(vb.vsync),       32'(e.vs));
        chk("B_line_start",  32'(vb.line_start),  32'(e.ls));
        chk("B_frame_start", 32'(vb.frame_start), 32'(e.fs));
    endtask

    // Drive enables from a negedge, pass one posedge, check at the following negedge
    task automatic step(bit ea, bit eb);
        va.enable = ea;
        vb.enable = eb;
        @(negedge pixclk);
        if (!reset) begin
            n_a += int'(ea);
            n_b += int'(eb);
        end
        check_a();
        check_b();
    endtask

    function automatic bit rnd_en();
        return ($urandom % 4) != 0;
    endfunction

    initial begin
        int run_hs, prev_x, last_fs, cyc, k;
        bit prev_hs;

        cfg_a = '{ha:640, hfp:16, hsw:96, hbp:48, va:4, vfp:1, vsw:2, vbp:1, dly:1, hp:1'b1, vp:1'b1};
        cfg_b = '{ha:4,   hfp:1,  hsw:2,  hbp:1,  va:3, vfp:1, vsw:1, vbp:1, dly:3, hp:1'b0, vp:1'b0};

        reset     = 1'b1;
        va.enable = 1'b0;
        vb.enable = 1'b0;
        n_a = 0;
        n_b = 0;
        #2;
        check_a();
        check_b();
        repeat (3) @(negedge pixclk);
        reset = 1'b0;
        check_a();
        check_b();

        // Free-running: hsync width/position on A, frame period on B
        run_hs  = 0;
        prev_x  = 0;
        prev_hs = va.hsync;
        last_fs = -1;
        for (cyc = 0; cyc < 2000; cyc++) begin
            prev_x  = int'(va.x);
            prev_hs = va.hsync;
            step(1'b1, 1'b1);
            if (va.hsync && !prev_hs) chk("A_hsync_rise_prev_x", 32'(prev_x), 32'd656);
            if (va.hsync) begin
                run_hs++;
            end else if (run_hs != 0) begin
                chk("A_hsync_width", 32'(run_hs), 32'd96);
                run_hs = 0;
            end
            if (vb.frame_start) begin
                if (last_fs >= 0) chk("B_frame_period", 32'(cyc - last_fs), 32'd48);
                last_fs = cyc;
            end
        end

        // Random enable gaps on both blocks
        for (int i = 0; i < 3000; i++) step(rnd_en(), rnd_en());

        // Mid-frame asynchronous reset at A's x=300,y=2
        k = 0;
        while (!(va.x == 10'd300 && va.y == 10'd2) && k < 7000) begin
            step(1'b1, rnd_en());
            k++;
        end
        chk("A_reach_300_2", 32'(va.x == 10'd300 && va.y == 10'd2), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        n_a = 0;
        n_b = 0;
        check_a();
        check_b();
        @(negedge pixclk);
        @(negedge pixclk);
        check_a();
        check_b();
        reset = 1'b0;
        step(1'b1, 1'b1);
        chk("A_fs_after_reset", 32'(va.frame_start), 32'd1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("B_fs_after_reset", 32'(vb.frame_start), 32'd1);
        for (int i = 0; i < 200; i++) step(1'b1, rnd_en());

        // Last pixel of the frame: hold with enable low, then wrap
        k = 0;
        while (!(va.x == 10'd799 && va.y == 10'd7) && k < 7000) begin
            step(1'b1, rnd_en());
            k++;
        end
        chk("A_reach_799_7", 32'(va.x == 10'd799 && va.y == 10'd7), 32'd1);
        repeat (3) step(1'b0, rnd_en());
        chk("A_hold_x", 32'(va.x), 32'd799);
        chk("A_hold_y", 32'(va.y), 32'd7);
        step(1'b1, rnd_en());
        chk("A_wrap_x", 32'(va.x), 32'd0);
        chk("A_wrap_y", 32'(va.y), 32'd0);
        for (int i = 0; i < 50; i++) step(rnd_en(), rnd_en());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
